// File: rtl/alu_bus_pkg.sv
// alu_bus_pkg
// Shared definitions for the ALU bus capture path: sequencer state encoding,
// default bus/opcode widths and the ALU operation codes that the ALU itself
// decodes. The capture block only latches the opcode; the codes live here so
// the ALU and anything driving op_in agree on one set of values.
package alu_bus_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_OPW   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [DEFAULT_OPW-1:0] OP_ADD = 4'h0;
  localparam logic [DEFAULT_OPW-1:0] OP_AND = 4'h1;
  localparam logic [DEFAULT_OPW-1:0] OP_OR  = 4'h2;
  localparam logic [DEFAULT_OPW-1:0] OP_XOR = 4'h3;

endpackage

// File: rtl/bus_reg.sv
// bus_reg
// WIDTH-bit holding register with synchronous active-high reset and a load
// enable. Used for the A and B operands and the captured ALU result.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset, clears q_o
//   load_i  - load d_i on the next rising edge
//   d_i     - data to load
//   q_o     - registered value
module bus_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/alu_bus_capture.sv
// alu_bus_capture
// Bus-side operand sequencer for the ALU. Reads operand A then operand B off
// the shared data bus, presents the latched opcode/subtract select, enables
// the ALU's tristate driver for a single cycle and captures the driven result
// and carry back off the bus. Result and flags are held for the control unit
// until the next completed execution.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; opcode and subtract latched on start
// LOAD_A  | waiting for bus_valid to load operand A
// LOAD_B  | waiting for bus_valid to load operand B
// EXEC    | ALU drives the bus; result/carry/zero captured at cycle end
// DONE    | one-cycle done pulse, result and flags valid
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - begin an operation (IDLE only)
//   op_in, sub_in   - operation and subtract select, latched on start
//   abort           - cancel an in-flight operation (non-IDLE only)
//   bus_in          - shared data bus
//   bus_valid       - bus carries an operand this cycle
//   alu_cout        - ALU carry-out, sampled during EXEC
//   a_reg, b_reg    - operands to the ALU
//   op_new, sub     - latched operation controls to the ALU
//   alu_out_en      - ALU tristate driver enable
//   busy, done      - status to the control unit
//   result          - captured ALU result
//   carry_flag      - captured carry
//   zero_flag       - captured result was zero
module alu_bus_capture
  import alu_bus_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   op_in,
  input  logic             sub_in,
  input  logic             abort,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_valid,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] b_reg,
  output logic [OPW-1:0]   op_new,
  output logic             sub,
  output logic             alu_out_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag
);

  state_e         state_q;
  state_e         state_d;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_d;
  logic           sub_q;
  logic           sub_d;
  logic           carry_q;
  logic           carry_d;
  logic           zero_q;
  logic           zero_d;

  logic start_acc;
  logic kill;
  logic load_a;
  logic load_b;
  logic capture;

  // Abort only matters once an operation is in flight; in IDLE a concurrent
  // start is accepted regardless of abort.
  assign start_acc = (state_q == ST_IDLE) && start;
  assign kill      = (state_q != ST_IDLE) && abort;

  // Abort suppresses every register update in the cycle it is seen.
  assign load_a  = (state_q == ST_LOAD_A) && bus_valid && !abort;
  assign load_b  = (state_q == ST_LOAD_B) && bus_valid && !abort;
  assign capture = (state_q == ST_EXEC) && !abort;

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_LOAD_A;
        ST_LOAD_A: if (bus_valid) state_d = ST_LOAD_B;
        ST_LOAD_B: if (bus_valid) state_d = ST_EXEC;
        ST_EXEC:   state_d = ST_DONE;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op_d    = op_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (start_acc) begin
      op_d  = op_in;
      sub_d = sub_in;
    end
    if (capture) begin
      carry_d = alu_cout;
      zero_d  = (bus_in == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  bus_reg #(.WIDTH(WIDTH)) u_a_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_a),
    .d_i    (bus_in),
    .q_o    (a_reg)
  );

  bus_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_b),
    .d_i    (bus_in),
    .q_o    (b_reg)
  );

  bus_reg #(.WIDTH(WIDTH)) u_result_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (capture),
    .d_i    (bus_in),
    .q_o    (result)
  );

  // Pure state decodes keep the driver enable and done pulse glitch-free.
  assign alu_out_en = (state_q == ST_EXEC);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign op_new     = op_q;
  assign sub        = sub_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;

endmodule

// File: tb/tb_alu_bus_capture.sv
module tb_alu_bus_capture;
  import alu_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] op_in = '0;
  logic       sub_in = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] bus_in = '0;
  logic       bus_valid = 1'b0;
  logic       alu_cout = 1'b0;
  logic [7:0] a_reg, b_reg, result;
  logic [3:0] op_new;
  logic       sub, alu_out_en, busy, done, carry_flag, zero_flag;

  alu_bus_capture #(.WIDTH(8), .OPW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_in(op_in), .sub_in(sub_in),
    .abort(abort), .bus_in(bus_in), .bus_valid(bus_valid), .alu_cout(alu_cout),
    .a_reg(a_reg), .b_reg(b_reg), .op_new(op_new), .sub(sub),
    .alu_out_en(alu_out_en), .busy(busy), .done(done), .result(result),
    .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference view of what the control unit should see.
  logic [7:0] exp_a = '0, exp_b = '0, exp_res = '0;
  logic [3:0] exp_op = '0;
  logic       exp_sub = 1'b0, exp_c = 1'b0, exp_z = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    exp_a = '0; exp_b = '0; exp_res = '0; exp_op = '0;
    exp_sub = 1'b0; exp_c = 1'b0; exp_z = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_a"}, a_reg, exp_a);
    chk({tag, "_b"}, b_reg, exp_b);
    chk({tag, "_op"}, op_new, exp_op);
    chk({tag, "_sub"}, sub, exp_sub);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_c"}, carry_flag, exp_c);
    chk({tag, "_z"}, zero_flag, exp_z);
  endtask

  task automatic chk_status(input string tag, input logic b, input logic en, input logic d);
    chk({tag, "_busy"}, busy, b);
    chk({tag, "_en"}, alu_out_en, en);
    chk({tag, "_done"}, done, d);
  endtask

  // Behavioural ALU: returns {carry, result}.
  function automatic logic [8:0] alu_model(input logic [3:0] op, input logic s,
                                           input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  alu_model = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
      OP_AND:  alu_model = {1'b0, a & b};
      OP_OR:   alu_model = {1'b0, a | b};
      OP_XOR:  alu_model = {1'b0, a ^ b};
      default: alu_model = {1'b0, a};
    endcase
  endfunction

  // Idle cycles with noise on bus_valid/abort; nothing may change.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus_valid = 1'($urandom_range(0, 1));
      bus_in    = 8'($urandom);
      abort     = 1'($urandom_range(0, 1));
      alu_cout  = 1'($urandom_range(0, 1));
      tick();
      chk_status("idle", 1'b0, 1'b0, 1'b0);
      chk_regs("idle");
    end
    bus_valid = 1'b0;
    abort     = 1'b0;
    alu_cout  = 1'b0;
  endtask

  // kill: 0 none, 1 abort in LOAD_A, 2 abort in LOAD_B, 3 abort in EXEC,
  //       4 reset in LOAD_B
  task automatic run_op(input logic [3:0] op, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input int sa, input int sb,
                        input int kill, input logic hold_start);
    int t0;
    logic [8:0] r;
    start  = 1'b1;
    op_in  = op;
    sub_in = s;
    abort  = 1'($urandom_range(0, 1));
    bus_valid = 1'($urandom_range(0, 1));
    bus_in = 8'($urandom);
    tick();
    t0 = cyc;
    start = 1'b0;
    abort = 1'b0;
    op_in = 4'($urandom);
    sub_in = 1'($urandom_range(0, 1));
    exp_op = op;
    exp_sub = s;
    chk_status("lda", 1'b1, 1'b0, 1'b0);
    chk_regs("lda");

    for (int i = 0; i < sa; i++) begin
      bus_valid = 1'b0;
      bus_in = 8'($urandom);
      tick();
      chk_status("stall_a", 1'b1, 1'b0, 1'b0);
      chk("stall_a_a", a_reg, exp_a);
    end
    bus_valid = 1'b1;
    bus_in = a;
    if (kill == 1) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      bus_valid = 1'b0;
      chk_status("abort_a", 1'b0, 1'b0, 1'b0);
      chk_regs("abort_a");
      return;
    end
    tick();
    exp_a = a;
    chk_status("ldb", 1'b1, 1'b0, 1'b0);
    chk("ldb_a", a_reg, exp_a);

    for (int i = 0; i < sb; i++) begin
      bus_valid = 1'b0;
      bus_in = 8'($urandom);
      tick();
      chk_status("stall_b", 1'b1, 1'b0, 1'b0);
      chk("stall_b_b", b_reg, exp_b);
    end
    bus_valid = 1'b1;
    bus_in = b;
    if (kill == 2) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      bus_valid = 1'b0;
      chk_status("abort_b", 1'b0, 1'b0, 1'b0);
      chk_regs("abort_b");
      return;
    end
    if (kill == 4) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus_valid = 1'b0;
      model_reset();
      chk_status("rst_b", 1'b0, 1'b0, 1'b0);
      chk_regs("rst_b");
      return;
    end
    tick();
    exp_b = b;
    chk_status("exec", 1'b1, 1'b1, 1'b0);
    chk("exec_b", b_reg, exp_b);

    // ALU drives the bus in EXEC; bus_valid is ignored here.
    bus_valid = 1'($urandom_range(0, 1));
    if (kill == 3) begin
      bus_in = 8'($urandom);
      alu_cout = 1'($urandom_range(0, 1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      bus_valid = 1'b0;
      alu_cout = 1'b0;
      chk_status("abort_x", 1'b0, 1'b0, 1'b0);
      chk_regs("abort_x");
      return;
    end
    r = alu_model(op, s, a, b);
    bus_in = r[7:0];
    alu_cout = r[8];
    tick();
    bus_valid = 1'b0;
    alu_cout = 1'b0;
    exp_res = r[7:0];
    exp_c = r[8];
    exp_z = (r[7:0] == 8'h00);
    chk_status("done", 1'b1, 1'b0, 1'b1);
    chk_regs("done");
    chk("latency", cyc - t0, 3 + sa + sb);

    start = hold_start;
    op_in = 4'($urandom);
    tick();
    start = 1'b0;
    chk_status("post", 1'b0, 1'b0, 1'b0);
    chk_regs("post");
  endtask

  initial begin
    // Reset held two cycles with bus_valid toggling.
    rst = 1'b1;
    bus_valid = 1'b1;
    bus_in = 8'hA5;
    tick();
    bus_valid = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
    chk_status("reset", 1'b0, 1'b0, 1'b0);
    chk_regs("reset");
    idle(2);

    // Basic add, start held during DONE must be ignored.
    run_op(OP_ADD, 1'b0, 8'h3C, 8'h05, 0, 0, 0, 1'b1);
    chk("add_res", result, 32'h41);
    idle(1);

    // Abort in EXEC keeps prior result 41.
    run_op(OP_ADD, 1'b0, 8'h10, 8'h20, 0, 0, 3, 1'b0);
    chk("abort_keep41", result, 32'h41);
    idle(1);

    // Carry and zero.
    run_op(OP_ADD, 1'b0, 8'hFF, 8'h01, 0, 0, 0, 1'b0);
    chk("cz_res", result, 32'h00);
    chk("cz_c", carry_flag, 1);
    chk("cz_z", zero_flag, 1);

    // Stalled operands: completion shifts by 8 cycles.
    run_op(OP_XOR, 1'b0, 8'h5A, 8'h0F, 5, 3, 0, 1'b0);

    // Reset mid LOAD_B, then a normal operation.
    run_op(OP_OR, 1'b1, 8'h12, 8'h34, 1, 1, 4, 1'b0);
    run_op(OP_ADD, 1'b1, 8'h20, 8'h21, 0, 2, 0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k > 4) k = 0;
      run_op(4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
             8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), k,
             1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_bus_capture.md
# alu_bus_capture

Bus-side reader and operand sequencer for the ALU. Captures two operands from the shared 8-bit data bus into the A and B operand registers and drives the ALU operation controls. It then enables the ALU's tristate driver for exactly one cycle, samples the driven result and carry back off the bus, and holds result and flags for the control unit. It sits between the shared bus, the ALU/tristate output stage and the control unit.

## Interface
Parameters:
- WIDTH, 8, data bus and operand width
- OPW, 4, ALU operation code width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin an operation; honoured only in IDLE
- op_in  input  OPW  ALU operation, latched on accepted start
- sub_in  input  1  subtract select, latched on accepted start
- abort  input  1  cancel any in-flight operation
- bus_in  input  WIDTH  shared data bus value
- bus_valid  input  1  bus carries a valid operand this cycle
- alu_cout  input  1  ALU carry-out
- a_reg  output  WIDTH  operand A to ALU
- b_reg  output  WIDTH  operand B to ALU
- op_new  output  OPW  latched operation to ALU
- sub  output  1  latched subtract select to ALU
- alu_out_en  output  1  enables ALU tristate bus driver
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  captured ALU result
- carry_flag  output  1  captured carry
- zero_flag  output  1  result == 0

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, DONE.
- IDLE: start=1 latches op_in and sub_in and moves to LOAD_A. bus_valid is ignored.
- LOAD_A: on bus_valid=1, a_reg ← bus_in and move to LOAD_B. Otherwise wait with no limit.
- LOAD_B: on bus_valid=1, b_reg ← bus_in and move to EXEC.
- EXEC: alu_out_en=1 for exactly this one cycle; bus_valid is ignored. At the cycle end, result ← bus_in, carry_flag ← alu_cout, zero_flag ← (bus_in == 0). Then move to DONE.
- DONE: done=1 for one cycle, then return to IDLE. start is ignored in DONE.
- abort=1 in any non-IDLE state returns to IDLE at the next edge:
  - a_reg and b_reg keep whatever was already loaded;
  - result and flags are not updated;
  - done is not asserted;
  - abort has priority over bus_valid and over the EXEC capture.
- abort in IDLE has no effect. If start and abort are both high in IDLE, start wins.
- result, carry_flag and zero_flag hold their values until the next completed EXEC.
- Widths: all registers are exactly WIDTH. No extension or truncation is applied; the carry is carried only in carry_flag.

## Timing
- Reset values:
  - state = IDLE;
  - a_reg, b_reg, result = 0;
  - op_new = 0, sub = 0;
  - alu_out_en = 0, busy = 0, done = 0;
  - carry_flag = 0, zero_flag = 0.
- All outputs are registered or decoded from state only. alu_out_en and done are state decodes, so they are glitch-free relative to clk.
- Minimum latency, with start accepted at edge n and bus_valid high in the next two cycles:
  - LOAD_A during cycle n+1;
  - LOAD_B during n+2;
  - EXEC during n+3 (alu_out_en high);
  - DONE during n+4 (done high, result and flags valid);
  - IDLE during n+5.
- Result and flags become visible in the same cycle that done is high.
- rst mid-operation overrides everything: all outputs return to reset values at the next edge.
- The bus is driven by the ALU only while alu_out_en=1. The block never enables the ALU driver in LOAD_A or LOAD_B, so there is no contention with external operand sources.

## Structure
- Shared package alu_bus_pkg:
  - state enum encoding (3-bit);
  - WIDTH/OPW defaults;
  - ALU operation code constants shared with the ALU.
- One sub-module, bus_reg: a WIDTH-bit register with synchronous reset and load enable. It is instantiated for a_reg, b_reg and result.
- FSM, control latches and flag logic live in the top module.

## Test plan
- Reset then idle: assert rst for 2 cycles with bus_valid toggling → all outputs 0, busy=0, state stays IDLE.
- Basic add: start with op=ADD, sub=0; bus 8'h3C then 8'h05; ALU model drives 8'h41, cout=0 → a_reg=3C, b_reg=05, alu_out_en high exactly 1 cycle, done at n+4, result=41, carry=0, zero=0.
- Carry and zero: operands FF and 01, model drives 00 with cout=1 → result=00, carry_flag=1, zero_flag=1.
- Stalled operands: bus_valid low for 5 cycles in LOAD_A and 3 cycles in LOAD_B → block waits, busy stays 1, and completion shifts by exactly 8 cycles.
- Abort in EXEC with prior result 41 → returns to IDLE, no done pulse, result stays 41. A start held during DONE is ignored.
- Reset mid-LOAD_B: rst in LOAD_B → all outputs zero next cycle. A new start then completes normally.
